hex_text_scroller: RTL and testbench



---
 rtl/hex_text_pkg.sv | 31 +++
 rtl/seg_char_decoder.sv | 19 +
 rtl/hex_text_scroller.sv | 130 +++++++++++++
 tb/tb_hex_text_scroller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_text_pkg.sv
// Shared types, segment tables and FSM states for the scrolling hex text display.
package hex_text_pkg;

    typedef struct packed {
        logic       is_digit;
        logic [4:0] idx;
    } char_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Out-of-range digit code; the decoder renders it blank, so it doubles as "no character".
    localparam char_t CHAR_BLANK = '{is_digit: 1'b1, idx: 5'd31};

    // Active-low {dp,g,f,e,d,c,b,a}; every glyph distinct, dp always off.
    localparam logic [7:0] LETTER_SEG [26] = '{
        8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC2, 8'h89, 8'hCF, 8'hE1,
        8'h8A, 8'hC7, 8'hC8, 8'hAB, 8'hA3, 8'h8C, 8'h98, 8'hAF, 8'h93, 8'h87,
        8'hC1, 8'hE3, 8'hD5, 8'hB6, 8'h91, 8'hA5
    };

    localparam logic [7:0] DIGIT_SEG [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHOW
    } state_t;

endpackage

// File: rtl/seg_char_decoder.sv
// Combinational character-to-segment decoder; invalid codes render blank.
module seg_char_decoder
    import hex_text_pkg::*;
(
    input  char_t      ch_i,
    output logic [7:0] seg_o
);

    // Table lookup by class, blank when the index is outside that class.
    always_comb begin
        seg_o = SEG_BLANK;
        if (ch_i.is_digit) begin
            if (ch_i.idx <= 5'd9) seg_o = DIGIT_SEG[ch_i.idx[3:0]];
        end else if (ch_i.idx <= 5'd25) begin
            seg_o = LETTER_SEG[ch_i.idx];
        end
    end

endmodule

// File: rtl/hex_text_scroller.sv
// Message buffer, load/show FSM, scroll divider and registered HEX outputs.
module hex_text_scroller
    import hex_text_pkg::*;
#(
    parameter int unsigned N_DIGITS = 6,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic                         CLOCK_50,
    input  logic                         RST_N,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_char,
    input  logic                         in_is_digit,
    input  logic                         in_last,
    input  logic                         clear,
    input  logic                         scroll_en,
    output logic [8*N_DIGITS-1:0]        HEX,
    output logic [$clog2(DEPTH+1)-1:0]   msg_len
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t                state_q, state_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         ofs_q, ofs_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [8*N_DIGITS-1:0] hex_q, hex_d;
    char_t                 buf_q [DEPTH];
    char_t                 disp_char [N_DIGITS];
    logic                  accept;
    logic                  long_msg;
    logic                  tick;
    logic [LW:0]           pos;

    assign accept   = in_valid && ready_q && !clear;
    assign long_msg = 32'(len_q) > N_DIGITS;
    assign tick     = (state_q == ST_SHOW) && scroll_en && long_msg && (cnt_q == TICK_LAST);

    assign in_ready = ready_q;
    assign msg_len  = len_q;
    assign HEX      = hex_q;

    // Next state: clear beats accept; accept may end loading; SHOW advances the scroll divider.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ofs_d   = ofs_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_IDLE;
            len_d   = '0;
            ofs_d   = '0;
            cnt_d   = '0;
        end else if (accept) begin
            len_d   = len_q + 1'b1;
            ofs_d   = '0;
            cnt_d   = '0;
            state_d = (in_last || len_d == DEPTH_L) ? ST_SHOW : ST_LOAD;
        end else if (state_q == ST_SHOW && scroll_en && long_msg) begin
            if (tick) begin
                cnt_d = '0;
                ofs_d = (ofs_q == len_q) ? '0 : ofs_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Ready is registered, so derive it from where the FSM is heading.
        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD && len_d < DEPTH_L);
    end

    // Pick the character for each digit: static left-aligned, or a circular window of period len+1.
    always_comb begin
        pos = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            disp_char[k] = CHAR_BLANK;
            if (state_q == ST_SHOW) begin
                if (!long_msg) begin
                    if (k < 32'(len_q)) disp_char[k] = buf_q[IW'(k)];
                end else begin
                    // ofs <= len and k < len, so one conditional subtract performs the modulo.
                    pos = {1'b0, ofs_q} + (LW+1)'(k);
                    if (pos > {1'b0, len_q}) pos = pos - {1'b0, len_q} - 1'b1;
                    if (pos != {1'b0, len_q}) disp_char[k] = buf_q[IW'(pos)];
                end
            end
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
        seg_char_decoder u_dec (
            .ch_i  (disp_char[g]),
            .seg_o (hex_d[8*(N_DIGITS-1-g) +: 8])
        );
    end

    // FSM and control registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            ofs_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ofs_q   <= ofs_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Output register: HEX trails state/ofs/buffer by one cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) hex_q <= '1;
        else        hex_q <= hex_d;
    end

    // Message buffer write on accept.
    always_ff @(posedge CLOCK_50) begin
        if (RST_N && accept) buf_q[IW'(len_q)] <= '{is_digit: in_is_digit, idx: in_char};
    end

endmodule

// File: tb/tb_hex_text_scroller.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural display model.
module tb_hex_text_scroller;

    localparam int N  = 6;
    localparam int D  = 16;
    localparam int TD = 4;
    localparam int LW = $clog2(D + 1);

    logic          CLOCK_50 = 1'b0;
    logic          RST_N = 1'b0;
    logic          in_valid = 1'b0;
    logic [4:0]    in_char = '0;
    logic          in_is_digit = 1'b0;
    logic          in_last = 1'b0;
    logic          clear = 1'b0;
    logic          scroll_en = 1'b0;
    logic          in_ready;
    logic [8*N-1:0] HEX;
    logic [LW-1:0] msg_len;

    hex_text_scroller #(.N_DIGITS(N), .DEPTH(D), .TICK_DIV(TD)) dut (
        .CLOCK_50    (CLOCK_50),
        .RST_N       (RST_N),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .in_is_digit (in_is_digit),
        .in_last     (in_last),
        .clear       (clear),
        .scroll_en   (scroll_en),
        .HEX         (HEX),
        .msg_len     (msg_len)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [7:0] lt [26] = '{
        8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'hC2, 8'h89, 8'hCF, 8'hE1,
        8'h8A, 8'hC7, 8'hC8, 8'hAB, 8'hA3, 8'h8C, 8'h98, 8'hAF, 8'h93, 8'h87,
        8'hC1, 8'hE3, 8'hD5, 8'hB6, 8'h91, 8'hA5
    };
    logic [7:0] dg [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Model: phase 0 idle, 1 load, 2 show; m_c counts enabled scroll cycles since entering show.
    int             m_state = 0;
    int             mbuf[$];
    int             m_c = 0;
    logic           m_ready = 1'b0;
    logic [8*N-1:0] m_hex = '1;
    int             errors = 0;
    int             checks = 0;

    function automatic logic [7:0] segof(int code);
        int idx;
        idx = code % 32;
        if (code >= 32) return (idx < 10) ? dg[idx] : 8'hFF;
        return (idx < 26) ? lt[idx] : 8'hFF;
    endfunction

    function automatic logic [8*N-1:0] render();
        logic [8*N-1:0] r;
        logic [7:0]     s;
        int             len, ofs, p;
        r   = '1;
        len = mbuf.size();
        ofs = (m_c / TD) % (len + 1);
        if (m_state != 2) return r;
        for (int k = 0; k < N; k++) begin
            s = 8'hFF;
            if (len <= N) begin
                if (k < len) s = segof(mbuf[k]);
            end else begin
                p = (ofs + k) % (len + 1);
                if (p != len) s = segof(mbuf[p]);
            end
            r[8*(N-1-k) +: 8] = s;
        end
        return r;
    endfunction

    task automatic model_step();
        if (!RST_N) begin
            m_state = 0;
            mbuf.delete();
            m_c     = 0;
            m_hex   = '1;
            m_ready = 1'b0;
            return;
        end
        m_hex = render();
        if (clear) begin
            m_state = 0;
            mbuf.delete();
            m_c = 0;
        end else if (in_valid && m_ready) begin
            mbuf.push_back(int'({in_is_digit, in_char}));
            if (in_last || mbuf.size() == D) begin
                m_state = 2;
                m_c     = 0;
            end else begin
                m_state = 1;
            end
        end else if (m_state == 2 && scroll_en && mbuf.size() > N) begin
            m_c++;
        end
        m_ready = (m_state == 0) || (m_state == 1 && mbuf.size() < D);
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(string name, logic [63:0] act, logic [63:0] mdl, logic [63:0] exp);
        check(name, act, exp);
        check({name, "_model"}, mdl, exp);
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_step();
        #1;
        check("HEX", 64'(HEX), 64'(m_hex));
        check("msg_len", 64'(msg_len), 64'(mbuf.size()));
        check("in_ready", 64'(in_ready), 64'(m_ready));
    endtask

    task automatic cycles(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic put(int idx, bit dig, bit last);
        in_valid    = 1'b1;
        in_char     = 5'(idx);
        in_is_digit = dig;
        in_last     = last;
        cycle();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        cycle();
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        // Reset held for two cycles
        cycles(2);
        lit("rst_hex", 64'(HEX), 64'(m_hex), 64'(48'hFFFF_FFFF_FFFF));
        lit("rst_ready", 64'(in_ready), 64'(m_ready), 64'd0);
        lit("rst_len", 64'(msg_len), 64'(mbuf.size()), 64'd0);
        RST_N = 1'b1;
        cycle();
        lit("ready_after_rst", 64'(in_ready), 64'(m_ready), 64'd1);

        // Short static message A,1,E
        scroll_en = 1'b1;
        put(0, 0, 0);
        put(1, 1, 0);
        put(4, 0, 1);
        idle();
        lit("short_hex", 64'(HEX), 64'(m_hex), 64'(48'h88F9_86FF_FFFF));
        cycles(20 * TD + 5);
        lit("short_static", 64'(HEX), 64'(m_hex), 64'(48'h88F9_86FF_FFFF));
        lit("short_ready", 64'(in_ready), 64'(m_ready), 64'd0);

        // Eight letters scroll with period 9
        do_clear();
        for (int i = 0; i < 8; i++) put(i, 0, i == 7);
        idle();
        lit("scroll_t1", 64'(HEX), 64'(m_hex), 64'(48'h8883_C6A1_868E));
        cycles(4);
        lit("scroll_B", 64'(HEX[47:40]), 64'(m_hex[47:40]), 64'h83);
        cycles(28);
        lit("scroll_gap", 64'(HEX[47:40]), 64'(m_hex[47:40]), 64'hFF);
        cycles(4);
        lit("scroll_wrap", 64'(HEX), 64'(m_hex), 64'(48'h8883_C6A1_868E));
        scroll_en = 1'b0;
        cycles(12);
        lit("scroll_frozen", 64'(HEX), 64'(m_hex), 64'(48'h8883_C6A1_868E));
        scroll_en = 1'b1;

        // Fill to DEPTH without in_last, then a 17th offer
        do_clear();
        for (int i = 0; i < D + 1; i++) put(i % 26, 0, 0);
        lit("full_len", 64'(msg_len), 64'(mbuf.size()), 64'd16);
        lit("full_ready", 64'(in_ready), 64'(m_ready), 64'd0);
        idle();
        cycles(10);

        // clear beats a simultaneous character in LOAD
        do_clear();
        put(2, 0, 0);
        put(3, 0, 0);
        in_valid = 1'b1;
        clear    = 1'b1;
        cycle();
        clear = 1'b0;
        lit("clear_len", 64'(msg_len), 64'(mbuf.size()), 64'd0);
        idle();
        lit("clear_hex", 64'(HEX), 64'(m_hex), 64'(48'hFFFF_FFFF_FFFF));

        // Out-of-range digit renders blank; then reset mid-scroll
        put(12, 1, 1);
        idle();
        lit("bad_digit", 64'(HEX), 64'(m_hex), 64'(48'hFFFF_FFFF_FFFF));
        lit("bad_len", 64'(msg_len), 64'(mbuf.size()), 64'd1);
        do_clear();
        put(0, 0, 0);
        put(1, 0, 0);
        put(12, 1, 0);
        put(3, 0, 0);
        put(4, 0, 0);
        put(5, 0, 0);
        put(6, 0, 1);
        idle();
        lit("mid_hex", 64'(HEX), 64'(m_hex), 64'(48'h8883_FFA1_868E));
        cycles(3 * TD + 1);
        RST_N = 1'b0;
        cycle();
        lit("mid_rst_hex", 64'(HEX), 64'(m_hex), 64'(48'hFFFF_FFFF_FFFF));
        RST_N = 1'b1;
        cycle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid    = ($urandom % 4) != 0;
            in_char     = 5'($urandom % 32);
            in_is_digit = $urandom % 2;
            in_last     = ($urandom % 8) == 0;
            clear       = ($urandom % 80) == 0;
            scroll_en   = ($urandom % 4) != 0;
            RST_N       = ($urandom % 300) != 0;
            cycle();
        end
        RST_N    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
